// File: rtl/alu_seq_if.sv
// Request/response bundle between the core sequencer and alu_seq.
interface alu_seq_if #(
    parameter int DATA_BUS_WIDTH = 8
);
    logic                      in_valid;
    logic                      in_ready;
    logic [4:0]                op;
    logic [DATA_BUS_WIDTH-1:0] register1;
    logic [DATA_BUS_WIDTH-1:0] register2;
    logic                      out_valid;
    logic [DATA_BUS_WIDTH-1:0] result;
    logic [DATA_BUS_WIDTH-1:0] result_hi;
    logic                      is_zero;
    logic                      is_carry;
    logic                      is_neg;

    modport master (
        output in_valid, op, register1, register2,
        input  in_ready, out_valid, result, result_hi, is_zero, is_carry, is_neg
    );

    modport slave (
        input  in_valid, op, register1, register2,
        output in_ready, out_valid, result, result_hi, is_zero, is_carry, is_neg
    );
endinterface

// File: rtl/alu_seq.sv
// Registered multi-cycle ALU with iterative SHLN/SHRN and optional shift-add MUL.
// Define ALU_SEQ_MUL_EN to build the multiplier; otherwise opcode 17 acts as NOP.
module alu_seq #(
    parameter int DATA_BUS_WIDTH = 8
) (
    input logic     clk,
    input logic     rst_n,
    alu_seq_if.slave bus
);
    localparam int W           = DATA_BUS_WIDTH;
    localparam int SHAMT_WIDTH = $clog2(DATA_BUS_WIDTH);

    typedef enum logic [4:0] {
        OP_NOP  = 5'd0,  OP_THR = 5'd1,  OP_ADD = 5'd2,  OP_SUB  = 5'd3,
        OP_ADC  = 5'd4,  OP_SBC = 5'd5,  OP_SHL = 5'd6,  OP_SHR  = 5'd7,
        OP_ROL  = 5'd8,  OP_ROR = 5'd9,  OP_AND = 5'd10, OP_OR   = 5'd11,
        OP_XOR  = 5'd12, OP_NOT = 5'd13, OP_ASR = 5'd14, OP_SHLN = 5'd15,
        OP_SHRN = 5'd16, OP_MUL = 5'd17
    } op_e;

    typedef enum logic {IDLE, BUSY} state_e;

    state_e                 state_q, state_d;
    logic [W-1:0]           result_q;
    logic                   zero_q, carry_q, neg_q, out_valid_q;
    logic [W-1:0]           sh_q;
    logic                   left_q;
    logic [SHAMT_WIDTH-1:0] cnt_q;

    logic [SHAMT_WIDTH-1:0] amt;
    logic                   fire, last_step, go_busy, done, upd;
    logic [W-1:0]           res_d;
    logic                   carry_d;
    logic [W:0]             arith;
    logic [W-1:0]           sh_src, sh_next;
    logic                   sh_left, sh_out;

`ifdef ALU_SEQ_MUL_EN
    logic [W-1:0] hi_q, acc_q, mq_q, mcand_q;
    logic         mul_q;
    logic [W-1:0] acc_src, mq_src, mc_src, acc_next, mq_next, hi_d;
    logic [W:0]   psum;
`endif

    assign amt       = bus.register2[SHAMT_WIDTH-1:0];
    assign fire      = bus.in_valid && (state_q == IDLE);
    assign last_step = (state_q == BUSY) && (cnt_q == '0);

    // The first shift step happens at the accepting edge, so BUSY covers k-1 steps.
    always_comb begin
        sh_src  = (state_q == IDLE) ? bus.register1 : sh_q;
        sh_left = (state_q == IDLE) ? (bus.op == OP_SHLN) : left_q;
        sh_next = sh_left ? {sh_src[W-2:0], 1'b0} : {1'b0, sh_src[W-1:1]};
        sh_out  = sh_left ? sh_src[W-1] : sh_src[0];
    end

`ifdef ALU_SEQ_MUL_EN
    // Right-shifting shift-add: after W steps {acc, mq} holds the full product.
    always_comb begin
        acc_src  = (state_q == IDLE) ? '0 : acc_q;
        mq_src   = (state_q == IDLE) ? bus.register2 : mq_q;
        mc_src   = (state_q == IDLE) ? bus.register1 : mcand_q;
        psum     = {1'b0, acc_src} + (mq_src[0] ? {1'b0, mc_src} : '0);
        acc_next = psum[W:1];
        mq_next  = {psum[0], mq_src[W-1:1]};
    end
`endif

    always_comb begin
        done    = 1'b0;
        upd     = 1'b0;
        go_busy = 1'b0;
        res_d   = result_q;
        carry_d = 1'b0;
        arith   = '0;
`ifdef ALU_SEQ_MUL_EN
        hi_d    = '0;
`endif
        if (fire) begin
            done = 1'b1;
            upd  = 1'b1;
            case (bus.op)
                OP_THR: res_d = bus.register1;
                OP_ADD: begin
                    arith   = {1'b0, bus.register1} + {1'b0, bus.register2};
                    res_d   = arith[W-1:0];
                    carry_d = arith[W];
                end
                OP_SUB: begin
                    arith   = {1'b0, bus.register1} - {1'b0, bus.register2};
                    res_d   = arith[W-1:0];
                    carry_d = arith[W];
                end
                OP_ADC: begin
                    arith   = {1'b0, bus.register1} + {1'b0, bus.register2} + {{W{1'b0}}, carry_q};
                    res_d   = arith[W-1:0];
                    carry_d = arith[W];
                end
                OP_SBC: begin
                    arith   = {1'b0, bus.register1} - {1'b0, bus.register2} - {{W{1'b0}}, carry_q};
                    res_d   = arith[W-1:0];
                    carry_d = arith[W];
                end
                OP_SHL: begin
                    res_d   = {bus.register1[W-2:0], 1'b0};
                    carry_d = bus.register1[W-1];
                end
                OP_SHR: begin
                    res_d   = {1'b0, bus.register1[W-1:1]};
                    carry_d = bus.register1[0];
                end
                OP_ROL: res_d = {bus.register1[W-2:0], bus.register1[W-1]};
                OP_ROR: res_d = {bus.register1[0], bus.register1[W-1:1]};
                OP_AND: res_d = bus.register1 & bus.register2;
                OP_OR:  res_d = bus.register1 | bus.register2;
                OP_XOR: res_d = bus.register1 ^ bus.register2;
                OP_NOT: res_d = ~bus.register1;
                OP_ASR: begin
                    res_d   = {bus.register1[W-1], bus.register1[W-1:1]};
                    carry_d = bus.register1[0];
                end
                OP_SHLN, OP_SHRN: begin
                    if (amt == '0) begin
                        res_d = bus.register1;
                    end else begin
                        res_d   = sh_next;
                        carry_d = sh_out;
                        if (amt != SHAMT_WIDTH'(1)) begin
                            done    = 1'b0;
                            upd     = 1'b0;
                            go_busy = 1'b1;
                        end
                    end
                end
`ifdef ALU_SEQ_MUL_EN
                OP_MUL: begin
                    done    = 1'b0;
                    upd     = 1'b0;
                    go_busy = 1'b1;
                end
`endif
                default: upd = 1'b0;
            endcase
        end else if (last_step) begin
            done = 1'b1;
            upd  = 1'b1;
`ifdef ALU_SEQ_MUL_EN
            if (mul_q) begin
                res_d   = mq_next;
                hi_d    = acc_next;
                carry_d = |acc_next;
            end else begin
                res_d   = sh_next;
                carry_d = sh_out;
            end
`else
            res_d   = sh_next;
            carry_d = sh_out;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (go_busy) state_d = BUSY;
            BUSY:    if (cnt_q == '0) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready = (state_q == IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            result_q    <= '0;
            zero_q      <= 1'b0;
            carry_q     <= 1'b0;
            neg_q       <= 1'b0;
            sh_q        <= '0;
            left_q      <= 1'b0;
            cnt_q       <= '0;
`ifdef ALU_SEQ_MUL_EN
            hi_q        <= '0;
            acc_q       <= '0;
            mq_q        <= '0;
            mcand_q     <= '0;
            mul_q       <= 1'b0;
`endif
        end else begin
            out_valid_q <= done;
            if (upd) begin
                result_q <= res_d;
                carry_q  <= carry_d;
                zero_q   <= (res_d == '0);
                neg_q    <= res_d[W-1];
`ifdef ALU_SEQ_MUL_EN
                hi_q     <= hi_d;
`endif
            end
            if (go_busy) begin
                sh_q   <= sh_next;
                left_q <= (bus.op == OP_SHLN);
                cnt_q  <= amt - SHAMT_WIDTH'(2);
`ifdef ALU_SEQ_MUL_EN
                mul_q   <= (bus.op == OP_MUL);
                acc_q   <= acc_next;
                mq_q    <= mq_next;
                mcand_q <= bus.register1;
                if (bus.op == OP_MUL) cnt_q <= SHAMT_WIDTH'(W - 2);
`endif
            end else if (state_q == BUSY) begin
                sh_q  <= sh_next;
                cnt_q <= cnt_q - SHAMT_WIDTH'(1);
`ifdef ALU_SEQ_MUL_EN
                acc_q <= acc_next;
                mq_q  <= mq_next;
`endif
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.is_zero   = zero_q;
    assign bus.is_carry  = carry_q;
    assign bus.is_neg    = neg_q;
`ifdef ALU_SEQ_MUL_EN
    assign bus.result_hi = hi_q;
`else
    assign bus.result_hi = '0;
`endif
endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: directed vector table, random ops against a reference model, reset abort.
module tb_alu_seq;
    localparam int W    = 8;
    localparam int MASK = (1 << W) - 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_seq_if #(.DATA_BUS_WIDTH(W)) bus ();
    alu_seq #(.DATA_BUS_WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct {
        int op; int a; int b;
        int res; int hi; int c; int z; int n; int lat;
    } vec_t;

    vec_t tbl[$];
    int total  = 0;
    int passed = 0;
    int m_res = 0, m_hi = 0, m_c = 0, m_z = 0, m_n = 0;

    function automatic void chk(string name, int act, int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endfunction

    // Reference: architectural result of one op plus its completion latency.
    task automatic model(input int o, input int a, input int b, output int lat);
        int r, hi, c, k;
        bit upd;
        r = 0; hi = 0; c = 0; upd = 1'b1; lat = 1;
        k = b % W;
        case (o)
            1:  r = a;
            2:  begin r = a + b; c = int'(r > MASK); end
            3:  begin c = int'(a < b); r = a - b; end
            4:  begin r = a + b + m_c; c = int'(r > MASK); end
            5:  begin c = int'(a < b + m_c); r = a - b - m_c; end
            6:  begin c = (a >> (W - 1)) & 1; r = a << 1; end
            7:  begin c = a & 1; r = a >> 1; end
            8:  r = (a << 1) | (a >> (W - 1));
            9:  r = (a >> 1) | ((a & 1) << (W - 1));
            10: r = a & b;
            11: r = a | b;
            12: r = a ^ b;
            13: r = ~a;
            14: begin c = a & 1; r = (a >> 1) | (a & (1 << (W - 1))); end
            15: begin r = a << k; c = (k != 0) ? ((a >> (W - k)) & 1) : 0; lat = (k != 0) ? k : 1; end
            16: begin r = a >> k; c = (k != 0) ? ((a >> (k - 1)) & 1) : 0; lat = (k != 0) ? k : 1; end
`ifdef ALU_SEQ_MUL_EN
            17: begin r = a * b; hi = ((a * b) >> W) & MASK; c = int'(hi != 0); lat = W; end
`endif
            default: upd = 1'b0;
        endcase
        if (upd) begin
            m_res = r & MASK;
            m_hi  = hi;
            m_c   = c;
            m_z   = int'(m_res == 0);
            m_n   = (m_res >> (W - 1)) & 1;
        end
    endtask

    // Called on a negedge; returns on the negedge where out_valid is seen (or timeout).
    task automatic run(input int o, input int a, input int b, input int e_res, input int e_hi,
                       input int e_c, input int e_z, input int e_n, input int e_lat, input string tag);
        int lat, busy_rdy;
        bit seen;
        chk({tag, " ready"}, int'(bus.in_ready), 1);
        bus.op        = 5'(o);
        bus.register1 = 8'(a);
        bus.register2 = 8'(b);
        bus.in_valid  = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid  = 1'b0;
        bus.register1 = 8'($urandom);
        bus.register2 = 8'($urandom);
        lat = 0; busy_rdy = 0; seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            lat++;
            if (bus.out_valid) seen = 1'b1;
            else if (bus.in_ready) busy_rdy++;
        end
        chk({tag, " latency"}, lat, e_lat);
        chk({tag, " ready_while_busy"}, busy_rdy, 0);
        chk({tag, " result"}, int'(bus.result), e_res);
        chk({tag, " result_hi"}, int'(bus.result_hi), e_hi);
        chk({tag, " carry"}, int'(bus.is_carry), e_c);
        chk({tag, " zero"}, int'(bus.is_zero), e_z);
        chk({tag, " neg"}, int'(bus.is_neg), e_n);
    endtask

    initial begin
        int lat, ov;
        bus.in_valid  = 1'b0;
        bus.op        = '0;
        bus.register1 = '0;
        bus.register2 = '0;

        //            op   a      b      res    hi     c  z  n  lat
        tbl.push_back('{2,  'hF0,  'h20,  'h10,  0,     1, 0, 0, 1});
        tbl.push_back('{4,  'h01,  'h01,  'h03,  0,     0, 0, 0, 1});
        tbl.push_back('{3,  'h05,  'h06,  'hFF,  0,     1, 0, 1, 1});
        tbl.push_back('{5,  'h10,  'h00,  'h0F,  0,     0, 0, 0, 1});
        tbl.push_back('{1,  'h80,  'h33,  'h80,  0,     0, 0, 1, 1});
        tbl.push_back('{10, 'hF0,  'h0F,  'h00,  0,     0, 1, 0, 1});
        tbl.push_back('{11, 'hF0,  'h0F,  'hFF,  0,     0, 0, 1, 1});
        tbl.push_back('{12, 'hAA,  'hFF,  'h55,  0,     0, 0, 0, 1});
        tbl.push_back('{13, 'h0F,  'h00,  'hF0,  0,     0, 0, 1, 1});
        tbl.push_back('{6,  'h81,  'h00,  'h02,  0,     1, 0, 0, 1});
        tbl.push_back('{7,  'h81,  'h00,  'h40,  0,     1, 0, 0, 1});
        tbl.push_back('{8,  'h81,  'h00,  'h03,  0,     0, 0, 0, 1});
        tbl.push_back('{9,  'h81,  'h00,  'hC0,  0,     0, 0, 1, 1});
        tbl.push_back('{14, 'h81,  'h00,  'hC0,  0,     1, 0, 1, 1});
        tbl.push_back('{0,  'h12,  'h34,  'hC0,  0,     1, 0, 1, 1});
        tbl.push_back('{2,  'hFF,  'h01,  'h00,  0,     1, 1, 0, 1});
        tbl.push_back('{15, 'h81,  'h03,  'h08,  0,     0, 0, 0, 3});
        tbl.push_back('{16, 'h81,  'h03,  'h10,  0,     0, 0, 0, 3});
        tbl.push_back('{16, 'h81,  'h00,  'h81,  0,     0, 0, 1, 1});
        tbl.push_back('{15, 'h01,  'h07,  'h80,  0,     0, 0, 1, 7});
        tbl.push_back('{16, 'h80,  'h07,  'h01,  0,     0, 0, 0, 7});
        tbl.push_back('{16, 'hFF,  'h01,  'h7F,  0,     1, 0, 0, 1});
        tbl.push_back('{15, 'hC0,  'hFA,  'h00,  0,     1, 1, 0, 2});
`ifdef ALU_SEQ_MUL_EN
        tbl.push_back('{17, 'hFF,  'hFF,  'h01,  'hFE,  1, 0, 0, 8});
`else
        tbl.push_back('{17, 'hFF,  'hFF,  'h00,  0,     1, 1, 0, 1});
`endif
        tbl.push_back('{2,  'h01,  'h01,  'h02,  0,     0, 0, 0, 1});
        tbl.push_back('{31, 'h55,  'h55,  'h02,  0,     0, 0, 0, 1});
        tbl.push_back('{4,  'h7F,  'h00,  'h7F,  0,     0, 0, 0, 1});

        // Reset held for two edges
        repeat (2) @(negedge clk);
        chk("reset in_ready", int'(bus.in_ready), 1);
        chk("reset out_valid", int'(bus.out_valid), 0);
        chk("reset result", int'(bus.result), 0);
        chk("reset result_hi", int'(bus.result_hi), 0);
        chk("reset flags", int'({bus.is_zero, bus.is_carry, bus.is_neg}), 0);
        rst_n = 1'b1;
        @(negedge clk);

        foreach (tbl[i]) begin
            model(tbl[i].op, tbl[i].a, tbl[i].b, lat);
            run(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].res, tbl[i].hi, tbl[i].c,
                tbl[i].z, tbl[i].n, tbl[i].lat, $sformatf("vec%0d", i));
        end

        for (int i = 0; i < 150; i++) begin
            int o, a, b;
            o = int'($urandom_range(0, 31));
            a = int'($urandom_range(0, MASK));
            b = int'($urandom_range(0, MASK));
            model(o, a, b, lat);
            run(o, a, b, m_res, m_hi, m_c, m_z, m_n, lat, $sformatf("rnd%0d op%0d", i, o));
        end

        model(1, 'hA5, 0, lat);
        run(1, 'hA5, 0, m_res, m_hi, m_c, m_z, m_n, lat, "pre_abort");

        // Abort a long SHLN by reset mid-flight
        ov = 0;
        bus.op = 5'd15; bus.register1 = 8'h01; bus.register2 = 8'h07; bus.in_valid = 1'b1;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        repeat (2) begin @(negedge clk); if (bus.out_valid) ov++; end
        rst_n = 1'b0;
        repeat (2) begin @(negedge clk); if (bus.out_valid) ov++; end
        rst_n = 1'b1;
        repeat (10) begin @(negedge clk); if (bus.out_valid) ov++; end
        chk("abort out_valid pulses", ov, 0);
        chk("abort result", int'(bus.result), 0);
        chk("abort result_hi", int'(bus.result_hi), 0);
        chk("abort flags", int'({bus.is_zero, bus.is_carry, bus.is_neg}), 0);
        chk("abort in_ready", int'(bus.in_ready), 1);
        m_res = 0; m_hi = 0; m_c = 0; m_z = 0; m_n = 0;

        model(4, 3, 4, lat);
        run(4, 3, 4, m_res, m_hi, m_c, m_z, m_n, lat, "post_abort");
        @(negedge clk);
        chk("out_valid single pulse", int'(bus.out_valid), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Registered, multi-cycle successor to the single-cycle datapath ALU, used by the core sequencer for every arithmetic, logic and shift operation.
- Accepts one operation per valid/ready handshake and returns registered result and flags.
- Adds carry-chained ADC/SBC, arithmetic shift and a negative flag.
- Adds iterative multi-bit shifts and an optional iterative multiply that run for several cycles while holding off new requests.

Parameters:
- DATA_BUS_WIDTH, 8, operand/result width; power of two, >= 4.
- SHAMT_WIDTH, $clog2(DATA_BUS_WIDTH), width of the shift-amount field taken from register2 (derived, do not override).

Ports:
- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- in_valid  in  1  request valid.
- in_ready  out  1  block can accept a request this cycle.
- op  in  5  opcode: 0 NOP, 1 THR, 2 ADD, 3 SUB, 4 ADC, 5 SBC, 6 SHL, 7 SHR, 8 ROL, 9 ROR, 10 AND, 11 OR, 12 XOR, 13 NOT, 14 ASR, 15 SHLN, 16 SHRN, 17 MUL; 18-31 undefined.
- register1  in  DATA_BUS_WIDTH  operand A.
- register2  in  DATA_BUS_WIDTH  operand B; low SHAMT_WIDTH bits are the shift amount for SHLN/SHRN.
- out_valid  out  1  one-cycle pulse when result/flags update.
- result  out  DATA_BUS_WIDTH  registered result, held until the next completion.
- result_hi  out  DATA_BUS_WIDTH  upper product half for MUL, 0 for all other ops.
- is_zero  out  1  registered zero flag.
- is_carry  out  1  registered carry/borrow flag; also the carry-in for ADC/SBC.
- is_neg  out  1  registered result MSB.

Behaviour:
- Reset (rst_n low at an edge): state IDLE; all outputs 0 except in_ready = 1. An in-flight multi-cycle op is aborted with no out_valid.
- Accept: in_valid && in_ready at an edge captures op and operands. Operands need not stay stable after acceptance.
- FSM states are IDLE and BUSY. in_ready = (state == IDLE).
- Single-cycle ops (everything except SHLN/SHRN with amount != 0, and MUL):
  - Outputs are written at the accepting edge; out_valid is high the following cycle.
  - State stays IDLE, so back-to-back accepts give one result per cycle.
- SHLN/SHRN with amount k > 0:
  - Accept moves to BUSY; one bit is shifted per cycle; the k-th shift writes the outputs and returns to IDLE.
  - out_valid is high k cycles after accept.
  - k = 0: single-cycle, result = register1, carry 0.
- MUL: BUSY for DATA_BUS_WIDTH cycles of shift-add; out_valid is high DATA_BUS_WIDTH cycles after accept.
- Arithmetic uses a DATA_BUS_WIDTH+1-bit intermediate:
  - ADD: carry = bit W.
  - SUB: carry = borrow.
  - ADC: r1 + r2 + is_carry.
  - SBC: r1 - r2 - is_carry, carry = borrow.
  - is_carry used by ADC/SBC is the registered flag value at the accepting edge.
- Shifts:
  - SHL: carry = r1 MSB. SHR: carry = r1 LSB.
  - ASR: sign-preserving right shift by 1, carry = r1 LSB.
  - SHLN/SHRN: logical shifts; carry = last bit shifted out.
  - ROL/ROR rotate by 1 with carry 0.
- Logic ops (AND/OR/XOR/NOT) and THR: carry 0.
- MUL: result = low W bits, result_hi = high W bits, carry = (result_hi != 0).
- Flags on every completion except NOP: is_zero = (result == 0), is_neg = result[W-1]. Note MUL zero/neg flags cover the low half only.
- NOP and undefined opcodes: accepted single-cycle; out_valid pulses; result, result_hi and all flags keep their previous values.
- result_hi is cleared to 0 on any completing non-NOP, non-MUL op.
- in_valid while BUSY is ignored; the requester must hold the request until in_ready.

Optional Feature:
- Macro ALU_SEQ_MUL_EN.
- Defined: MUL behaves as above.
- Undefined: opcode 17 is treated as undefined (NOP behaviour, single-cycle); no multiplier datapath or counter bits beyond the shifter are synthesised; result_hi is constant 0.

Test Plan:
- Reset, W=8: rst_n low 2 cycles -> in_ready=1, out_valid=0, result=0, result_hi=0, all flags 0.
- ADD 0xF0+0x20 then ADC 0x01+0x01, back-to-back -> 0x10 carry=1 on the first pulse; 0x03 carry=0 zero=0 on the next cycle; in_ready stays 1.
- SUB 0x05-0x06 -> result 0xFF, carry=1, neg=1. Then SBC 0x10-0x00 -> 0x0F, carry=0.
- SHRN r1=0x81, r2=0x03 -> in_ready low for cycles 1-2, out_valid 3 cycles after accept, result 0x10, carry=0. Same with r2=0 -> 1-cycle, result 0x81, carry 0.
- MUL (macro on) 0xFF*0xFF -> out_valid 8 cycles after accept, result 0x01, result_hi 0xFE, carry=1. Macro off: same request -> 1 cycle, outputs unchanged.
- Abort: accept SHLN k=7, assert rst_n low at cycle 3 -> no out_valid; all outputs reset; in_ready=1 after release.
